// File: rtl/connect_four_game_ctrl_pkg.sv
// Shared encodings for the connect-four controller: cell/winner codes,
// FSM states, scan directions and their row/column step table.
`timescale 1ns/1ps
package connect_four_game_ctrl_pkg;

  localparam int ROWS_DEF = 8;
  localparam int COLS_DEF = 8;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_PLACE,
    ST_CHECK,
    ST_OVER
  } state_t;

  // Evaluation order of the win check
  typedef enum logic [1:0] {
    DIR_H,   // horizontal
    DIR_V,   // vertical
    DIR_D,   // diagonal down-right
    DIR_A    // anti-diagonal down-left
  } dir_t;

  typedef struct packed {
    logic signed [1:0] dr;
    logic signed [1:0] dc;
  } step_t;

  // Positive walk step per direction; the negative walk uses the negation
  function automatic step_t dir_step(dir_t d);
    step_t s;
    case (d)
      DIR_H:   begin s.dr =  2'sd0; s.dc =  2'sd1; end
      DIR_V:   begin s.dr =  2'sd1; s.dc =  2'sd0; end
      DIR_D:   begin s.dr =  2'sd1; s.dc =  2'sd1; end
      default: begin s.dr =  2'sd1; s.dc = -2'sd1; end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/connect_four_game_ctrl_btn_sync.sv
// Two-flop synchronizer plus rising-edge detector; one-cycle pulse
// registered three cycles after the input rises.
`timescale 1ns/1ps
module btn_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  // [1:0] synchronize, [2] holds the previous synchronized level
  logic [2:0] sync_pipe;

  // Shift the level through and flag a 0->1 transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_pipe <= '0;
      pulse     <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[1:0], btn};
      pulse     <= sync_pipe[1] & ~sync_pipe[2];
    end
  end

endmodule

// File: rtl/connect_four_game_ctrl.sv
// Connect-four game controller: cursor, column scan, piece placement and
// a one-cell-per-cycle win walker over four directions.
`timescale 1ns/1ps
module connect_four_game_ctrl
  import connect_four_game_ctrl_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic                   clk_25MHz,
  input  logic                   rst_n,
  input  logic                   move_right,
  input  logic                   move_left,
  input  logic                   drop_piece,
  output logic [ROWS*COLS*2-1:0] board_out,
  output logic [2:0]             cursor_col,
  output logic [1:0]             cur_player,
  output logic [1:0]             winner,
  output logic                   busy
);

  localparam int CELLS = ROWS * COLS;
  localparam int BW    = 2 * CELLS;
  localparam int RW    = $clog2(ROWS);

  logic [2:0] btn_lvl, btn_pls;
  logic       right_p, left_p, drop_p;

  assign btn_lvl = {drop_piece, move_left, move_right};
  assign right_p = btn_pls[0];
  assign left_p  = btn_pls[1];
  assign drop_p  = btn_pls[2];

  btn_edge_sync u_sync [2:0] (
    .clk   (clk_25MHz),
    .rst_n (rst_n),
    .btn   (btn_lvl),
    .pulse (btn_pls)
  );

  state_t          state, state_nxt;
  logic [BW-1:0]   board_nxt;
  logic [2:0]      cursor_nxt, drop_col, col_nxt;
  logic [1:0]      player_nxt, winner_nxt;
  logic            busy_nxt;
  logic [6:0]      cnt, cnt_nxt;
  logic [RW-1:0]   row, row_nxt;
  dir_t            dir, dir_nxt;
  logic            walk_neg, neg_nxt;
  logic [1:0]      k, k_nxt;
  logic [2:0]      run, run_nxt, run_inc;

  step_t           st;
  int              sgn, pr, pc, idx;
  logic            in_bnds, match;
  logic [1:0]      rd_cell;

  // Next-state, board update and win walker
  always_comb begin
    state_nxt  = state;
    board_nxt  = board_out;
    cursor_nxt = cursor_col;
    player_nxt = cur_player;
    winner_nxt = winner;
    cnt_nxt    = cnt;
    col_nxt    = drop_col;
    row_nxt    = row;
    dir_nxt    = dir;
    neg_nxt    = walk_neg;
    k_nxt      = k;
    run_nxt    = run;

    // Walker target: anchor +/- k steps along the current direction
    st      = dir_step(dir);
    sgn     = walk_neg ? -1 : 1;
    pr      = int'(row)      + sgn * int'(k) * int'(st.dr);
    pc      = int'(drop_col) + sgn * int'(k) * int'(st.dc);
    in_bnds = (pr >= 0) && (pr < ROWS) && (pc >= 0) && (pc < COLS);

    // Outside CHECK the addressed cell is the scan/place anchor
    if (state != ST_CHECK) idx = int'(row) * COLS + int'(drop_col);
    else if (in_bnds)      idx = pr * COLS + pc;
    else                   idx = 0;

    rd_cell = 2'(board_out >> (2 * idx));
    match   = in_bnds && (rd_cell == cur_player);
    run_inc = run + 3'd1;

    case (state)
      ST_IDLE: begin
        if (drop_p) begin
          col_nxt   = cursor_col;
          row_nxt   = RW'(ROWS - 1);
          state_nxt = ST_SCAN;
        end else if (right_p && !left_p) begin
          if (cursor_col != 3'(COLS - 1)) cursor_nxt = cursor_col + 3'd1;
        end else if (left_p && !right_p) begin
          if (cursor_col != 3'd0) cursor_nxt = cursor_col - 3'd1;
        end
      end

      ST_SCAN: begin
        if (rd_cell == CELL_EMPTY) state_nxt = ST_PLACE;
        else if (row != '0)        row_nxt   = row - RW'(1);
        else                       state_nxt = ST_IDLE;  // column full
      end

      ST_PLACE: begin
        board_nxt = (board_out & ~(BW'(2'b11) << (2 * idx)))
                  | (BW'(cur_player) << (2 * idx));
        cnt_nxt   = cnt + 7'd1;
        dir_nxt   = DIR_H;
        neg_nxt   = 1'b0;
        k_nxt     = 2'd1;
        run_nxt   = 3'd1;
        state_nxt = ST_CHECK;
      end

      ST_CHECK: begin
        if (match && run_inc >= 3'd4) begin
          winner_nxt = cur_player;
          state_nxt  = ST_OVER;
        end else if (match && k != 2'd3) begin
          run_nxt = run_inc;
          k_nxt   = k + 2'd1;
        end else begin
          // Current walk ended: edge, mismatch or three steps taken
          if (match) run_nxt = run_inc;
          if (!walk_neg) begin
            neg_nxt = 1'b1;
            k_nxt   = 2'd1;
          end else if (dir != DIR_A) begin
            dir_nxt = dir_t'(2'(dir) + 2'd1);
            neg_nxt = 1'b0;
            k_nxt   = 2'd1;
            run_nxt = 3'd1;
          end else if (cnt == 7'(CELLS)) begin
            winner_nxt = WIN_DRAW;
            state_nxt  = ST_OVER;
          end else begin
            player_nxt = (cur_player == CELL_P1) ? CELL_P2 : CELL_P1;
            state_nxt  = ST_IDLE;
          end
        end
      end

      ST_OVER: begin
        if (drop_p) begin
          board_nxt  = '0;
          cnt_nxt    = 7'd0;
          winner_nxt = WIN_NONE;
          player_nxt = CELL_P1;
          state_nxt  = ST_IDLE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    busy_nxt = (state_nxt == ST_SCAN) || (state_nxt == ST_PLACE) ||
               (state_nxt == ST_CHECK);
  end

  // State, board and registered outputs
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      board_out  <= '0;
      cursor_col <= 3'd0;
      cur_player <= CELL_P1;
      winner     <= WIN_NONE;
      busy       <= 1'b0;
      cnt        <= 7'd0;
      drop_col   <= 3'd0;
      row        <= '0;
      dir        <= DIR_H;
      walk_neg   <= 1'b0;
      k          <= 2'd1;
      run        <= 3'd1;
    end else begin
      state      <= state_nxt;
      board_out  <= board_nxt;
      cursor_col <= cursor_nxt;
      cur_player <= player_nxt;
      winner     <= winner_nxt;
      busy       <= busy_nxt;
      cnt        <= cnt_nxt;
      drop_col   <= col_nxt;
      row        <= row_nxt;
      dir        <= dir_nxt;
      walk_neg   <= neg_nxt;
      k          <= k_nxt;
      run        <= run_nxt;
    end
  end

endmodule

// File: tb/tb_connect_four_game_ctrl.sv
// Scoreboard bench for connect_four_game_ctrl: a board model predicts each
// button action, the expectation is queued and checked once the DUT settles.
`timescale 1ns/1ps
module tb_connect_four_game_ctrl;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int BW   = ROWS * COLS * 2;

  logic          clk_25MHz = 1'b0;
  logic          rst_n = 1'b0;
  logic          move_right = 1'b0, move_left = 1'b0, drop_piece = 1'b0;
  logic [BW-1:0] board_out;
  logic [2:0]    cursor_col;
  logic [1:0]    cur_player, winner;
  logic          busy;

  always #20 clk_25MHz = ~clk_25MHz;

  connect_four_game_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk_25MHz  (clk_25MHz),
    .rst_n      (rst_n),
    .move_right (move_right),
    .move_left  (move_left),
    .drop_piece (drop_piece),
    .board_out  (board_out),
    .cursor_col (cursor_col),
    .cur_player (cur_player),
    .winner     (winner),
    .busy       (busy)
  );

  typedef struct {
    logic [BW-1:0] board;
    logic [2:0]    cur;
    logic [1:0]    pl;
    logic [1:0]    win;
    int            bmin;
    int            bmax;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  logic [1:0] m_board [ROWS][COLS];
  logic [2:0] m_cur;
  logic [1:0] m_pl, m_win;
  int         m_cnt;
  bit         m_over;

  function automatic logic [BW-1:0] m_pack();
    logic [BW-1:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        v[2*(r*COLS+c) +: 2] = m_board[r][c];
    return v;
  endfunction

  // Any four-in-a-row of player p anywhere on the model board
  function automatic bit m_four(logic [1:0] p);
    int dr [4] = '{0, 1, 1, 1};
    int dc [4] = '{1, 0, 1, -1};
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        for (int d = 0; d < 4; d++) begin
          bit ok;
          ok = 1'b1;
          for (int s = 0; s < 4; s++) begin
            int rr, cc;
            rr = r + s * dr[d];
            cc = c + s * dc[d];
            if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) ok = 1'b0;
            else if (m_board[rr][cc] != p) ok = 1'b0;
          end
          if (ok) return 1'b1;
        end
    return 1'b0;
  endfunction

  task automatic m_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        m_board[r][c] = 2'b00;
    m_pl = 2'b01; m_win = 2'b00; m_cnt = 0; m_over = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk_25MHz); #1;
    rst_n = 1'b0; move_right = 0; move_left = 0; drop_piece = 0;
    m_clear(); m_cur = 3'd0;
    exp_q.delete();
    repeat (2) @(posedge clk_25MHz);
    #1 rst_n = 1'b1;
  endtask

  // Predict, queue, drive one button pattern, then pop and compare
  task automatic act(input bit r, input bit l, input bit d, input string nm);
    exp_t e;
    int   bc, rr;
    e.bmin = 0; e.bmax = 0;
    if (d) begin
      if (m_over) m_clear();
      else begin
        rr = -1;
        for (int i = 0; i < ROWS; i++) if (m_board[i][m_cur] == 2'b00) rr = i;
        if (rr < 0) begin
          e.bmin = ROWS; e.bmax = ROWS;
        end else begin
          m_board[rr][m_cur] = m_pl;
          m_cnt++;
          e.bmin = 1; e.bmax = 34;
          if (m_four(m_pl)) begin m_win = m_pl; m_over = 1'b1; end
          else if (m_cnt == ROWS * COLS) begin m_win = 2'b11; m_over = 1'b1; end
          else m_pl = (m_pl == 2'b01) ? 2'b10 : 2'b01;
        end
      end
    end else if (!m_over && (r ^ l)) begin
      if (r && m_cur != 3'(COLS - 1)) m_cur = m_cur + 3'd1;
      if (l && m_cur != 3'd0)         m_cur = m_cur - 3'd1;
    end
    e.board = m_pack(); e.cur = m_cur; e.pl = m_pl; e.win = m_win;
    exp_q.push_back(e);

    @(posedge clk_25MHz); #1;
    move_right = r; move_left = l; drop_piece = d;
    bc = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk_25MHz); #1;
      if (i == 5) begin move_right = 0; move_left = 0; drop_piece = 0; end
      if (busy) bc++;
    end

    e = exp_q.pop_front();
    tests++;
    if (board_out !== e.board) begin
      fails++; $display("FAIL %s board: got %h want %h", nm, board_out, e.board);
    end
    tests++;
    if (cursor_col !== e.cur) begin
      fails++; $display("FAIL %s cursor: got %0d want %0d", nm, cursor_col, e.cur);
    end
    tests++;
    if (cur_player !== e.pl) begin
      fails++; $display("FAIL %s player: got %b want %b", nm, cur_player, e.pl);
    end
    tests++;
    if (winner !== e.win) begin
      fails++; $display("FAIL %s winner: got %b want %b", nm, winner, e.win);
    end
    tests++;
    if (bc < e.bmin || bc > e.bmax) begin
      fails++; $display("FAIL %s busy_cycles: got %0d want %0d..%0d", nm, bc, e.bmin, e.bmax);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL %s busy_timeout: got %b want 0", nm, busy);
    end
  endtask

  task automatic go_col(input int c);
    while (int'(m_cur) < c) act(1, 0, 0, "right");
    while (int'(m_cur) > c) act(0, 1, 0, "left");
  endtask

  task automatic drop_at(input int c);
    go_col(c);
    act(0, 0, 1, "drop");
  endtask

  task automatic check_const(input string nm, input logic [BW-1:0] got, input logic [BW-1:0] want);
    tests++;
    if (got !== want) begin
      fails++; $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_clear(); m_cur = 3'd0;
    repeat (3) @(posedge clk_25MHz);
    #1;
    check_const("reset_board",  board_out, '0);
    check_const("reset_cursor", BW'(cursor_col), BW'(0));
    check_const("reset_player", BW'(cur_player), BW'(1));
    check_const("reset_winner", BW'(winner), BW'(0));
    check_const("reset_busy",   BW'(busy), BW'(0));
    rst_n = 1'b1;
  endtask

  task automatic test_cursor();
    repeat (3) act(1, 0, 0, "right");
    act(0, 1, 0, "left");
    check_const("cursor_is_2", BW'(cursor_col), BW'(2));
    repeat (10) act(1, 0, 0, "right_sat");
    check_const("cursor_is_7", BW'(cursor_col), BW'(7));
    act(1, 1, 0, "both_ignored");
    repeat (9) act(0, 1, 0, "left_sat");
    check_const("cursor_is_0", BW'(cursor_col), BW'(0));
  endtask

  task automatic test_drop_col0();
    drop_at(0);
    drop_at(0);
    check_const("cell_7_0", BW'(board_out[2*(7*COLS+0) +: 2]), BW'(1));
    check_const("cell_6_0", BW'(board_out[2*(6*COLS+0) +: 2]), BW'(2));
    check_const("col0_player", BW'(cur_player), BW'(1));
  endtask

  task automatic test_full_column();
    do_reset();
    repeat (9) drop_at(3);
    check_const("full_player", BW'(cur_player), BW'(1));
  endtask

  task automatic test_horizontal_win();
    int cols [7] = '{0, 0, 1, 1, 2, 2, 3};
    do_reset();
    foreach (cols[i]) drop_at(cols[i]);
    check_const("hwin_winner", BW'(winner), BW'(1));
    act(1, 0, 0, "over_move");
    act(0, 0, 1, "restart");
    check_const("restart_board",  board_out, '0);
    check_const("restart_player", BW'(cur_player), BW'(1));
  endtask

  task automatic test_diag_win();
    int cols [12] = '{6, 4, 5, 5, 6, 7, 7, 0, 7, 7, 0, 6};
    do_reset();
    foreach (cols[i]) drop_at(cols[i]);
    check_const("diag_winner", BW'(winner), BW'(2));
    check_const("diag_cell_5_6", BW'(board_out[2*(5*COLS+6) +: 2]), BW'(2));
  endtask

  task automatic test_reset_mid_check();
    int  n;
    bit  seen;
    do_reset();
    drop_at(1);
    go_col(2);
    @(posedge clk_25MHz); #1;
    drop_piece = 1'b1;
    seen = 1'b0; n = 0;
    while (!seen && n < 10) begin
      @(posedge clk_25MHz); #1;
      if (busy) seen = 1'b1;
      n++;
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL midcheck_busy: got 0 want 1"); end
    // SCAN -> PLACE -> CHECK, then reset in the middle of the cycle
    repeat (2) @(posedge clk_25MHz);
    #10 rst_n = 1'b0;
    #1;
    check_const("midcheck_board",  board_out, '0);
    check_const("midcheck_cursor", BW'(cursor_col), BW'(0));
    check_const("midcheck_player", BW'(cur_player), BW'(1));
    check_const("midcheck_winner", BW'(winner), BW'(0));
    check_const("midcheck_busy",   BW'(busy), BW'(0));
    drop_piece = 1'b0;
    m_clear(); m_cur = 3'd0; exp_q.delete();
    repeat (2) @(posedge clk_25MHz);
    #1 rst_n = 1'b1;
    act(1, 0, 0, "post_reset_move");
    drop_at(4);
  endtask

  initial begin
    #(40 * 20000);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cursor();
    test_drop_col0();
    test_full_column();
    test_horizontal_win();
    test_diag_win();
    test_reset_mid_check();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/connect_four_game_ctrl.md
CONNECT_FOUR_GAME_CTRL -- requirements
Module: connect_four_game_ctrl

Interface
REQ-001: Parameter ROWS, default 8, board rows; row 0 is top.
REQ-002: Parameter COLS, default 8, board columns; column 0 is leftmost.
REQ-003: clk_25MHz  input  1  single clock for all state.
REQ-004: rst_n  input  1  asynchronous, active-low reset.
REQ-005: move_right  input  1  debounced button level; each rising edge requests cursor +1.
REQ-006: move_left  input  1  debounced button level; each rising edge requests cursor -1.
REQ-007: drop_piece  input  1  debounced button level; a rising edge drops a piece, or restarts the game from OVER.
REQ-008: board_out  output  ROWS*COLS*2  cell (r,c) at bits [2*(r*COLS+c)+1 : 2*(r*COLS+c)]; 00 empty, 01 player 1, 10 player 2, 11 never driven.
REQ-009: cursor_col  output  3  current column.
REQ-010: cur_player  output  2  01 or 10, the player to move.
REQ-011: winner  output  2  00 none, 01/10 winning player, 11 draw.
REQ-012: busy  output  1  high in SCAN, PLACE and CHECK.

Function
REQ-013: All three button inputs SHALL pass through a 2-flop synchronizer plus edge detector, giving a 1-cycle pulse per rising edge; a pulse appears 3 cycles after the input edge.
REQ-014: FSM states SHALL be IDLE, SCAN, PLACE, CHECK, OVER.
REQ-015: IDLE, move pulse only: cursor_col SHALL update next cycle, saturating at 0 and COLS-1 with no wrap.
REQ-016: IDLE, left and right pulses in the same cycle: both SHALL be ignored.
REQ-017: IDLE, drop pulse: move pulses in the same cycle SHALL be ignored; latch column = cursor_col; scan row = ROWS-1; go to SCAN.
REQ-018: SCAN SHALL examine one row per cycle: empty -> PLACE; occupied and row>0 -> row-1; occupied and row=0 -> column full, return to IDLE with no board or player change.
REQ-019: PLACE SHALL write cur_player into (row, column) in one cycle, increment a 7-bit piece counter, and go to CHECK.
REQ-020: CHECK SHALL test four directions in order: horizontal, vertical, diagonal down-right, anti-diagonal down-left.
REQ-021: Per direction: walk + up to 3 steps, then - up to 3 steps, one cell per cycle; each walk stops at the board edge or a non-matching cell; run = 1 + matches.
REQ-022: If run >= 4, winner SHALL be set to cur_player and the FSM SHALL go to OVER immediately, skipping remaining directions.
REQ-023: If all directions fail and the piece count = ROWS*COLS, winner SHALL be 11 and the FSM SHALL go to OVER.
REQ-024: Otherwise cur_player SHALL toggle (01<->10) and the FSM SHALL return to IDLE.
REQ-025: CHECK SHALL take at most 24 cycles; drop-to-IDLE latency SHALL be at most 8+1+24+1 cycles.
REQ-026: Move and drop pulses arriving while busy SHALL be discarded, not queued.
REQ-027: OVER SHALL ignore move pulses and hold the board and winner.
REQ-028: OVER, drop pulse: clear board, counter and winner; cur_player = 01; cursor_col kept; go to IDLE.
REQ-029: board_out, cursor_col, cur_player, winner and busy SHALL all be registered outputs.

Reset
REQ-030: On rst_n low, at any time and in any state, the controller SHALL asynchronously clear the board to all 00, cursor_col = 0, cur_player = 01, winner = 00, busy = 0, state = IDLE, counter = 0 and the synchronizers.
REQ-031: A reset asserted mid-SCAN or mid-CHECK SHALL discard the in-flight move with no partial write.

Structure
REQ-032: A shared package SHALL hold: the cell encoding constants, winner codes, FSM state enum, direction enum with row/col step table, and ROWS/COLS defaults.
REQ-033: One sub-module, btn_edge_sync (synchronizer + rising-edge pulse), SHALL be instantiated three times; the FSM, board register and walker SHALL be inline.

Verification
REQ-034: Reset, then 3 right presses, 1 left press -> cursor_col = 2; then 10 right presses -> cursor_col = 7.
REQ-035: Drop in column 0 twice -> (7,0) = 01, (6,0) = 10, cur_player = 01, busy low within 34 cycles of each pulse.
REQ-036: Column 3 filled with 8 drops, 9th drop -> busy for 8 cycles, board unchanged, cur_player unchanged.
REQ-037: Player 1 in (7,0..3), player 2 in (6,0..2) interleaved -> winner = 01 after the 7th drop; later move/drop pulses ignored until a drop restarts with a cleared board and cur_player = 01.
REQ-038: Diagonal win by player 2 at (7,4),(6,5),(5,6),(4,7), placed last at (5,6) -> winner = 10.
REQ-039: rst_n pulsed low during CHECK -> all outputs at reset values within the same cycle, no residual cell written.
